// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache for the fetch stage.
// A hit returns the selected word combinationally in the same cycle. A miss
// stalls fetch, fetches one 128-bit line over a req/ready handshake, spends
// one fill cycle, then replays the lookup against whatever in_PC is then.
// Optional feature macro: ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache #(
    parameter int NUM_LINES = 4,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          in_PC,
    input  logic                 in_req,
    input  logic                 in_invalidate,
    output logic [31:0]          out_instruction,
    output logic                 out_valid,
    output logic                 out_stall,
    output logic                 mem_req,
    output logic [31:0]          mem_addr,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]          out_hit_count,
    output logic [31:0]          out_miss_count
`endif
);

    localparam int IW    = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 4 - IW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    logic [31:0]          miss_addr;

    logic [IW-1:0]        lookup_index;
    logic [TAG_W-1:0]     lookup_tag;
    logic [1:0]           lookup_word;
    logic                 lookup_hit;
    logic [LINE_BITS-1:0] lookup_line;

    logic [IW-1:0]        fill_index;
    logic [TAG_W-1:0]     fill_tag;
    logic                 fill_we;
    logic                 start_miss;

    // The byte offset within a word never matters for 32-bit fetch.
    logic unused_pc_bits;
    assign unused_pc_bits = ^in_PC[1:0];

    assign lookup_word  = in_PC[3:2];
    assign lookup_index = in_PC[4+IW-1:4];
    assign lookup_tag   = in_PC[31:4+IW];
    assign lookup_line  = data_mem[lookup_index];

    assign lookup_hit = in_req && valid[lookup_index] &&
                        (tag_mem[lookup_index] == lookup_tag) &&
                        (state == IDLE);

    assign fill_index = miss_addr[4+IW-1:4];
    assign fill_tag   = miss_addr[31:4+IW];
    assign fill_we    = (state == MISS) && mem_ready;

    // Word select from the indexed line; only meaningful when out_valid is high.
    always_comb begin
        out_instruction = lookup_line[31:0];
        case (lookup_word)
            2'd0:    out_instruction = lookup_line[31:0];
            2'd1:    out_instruction = lookup_line[63:32];
            2'd2:    out_instruction = lookup_line[95:64];
            default: out_instruction = lookup_line[127:96];
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/stall outputs; memory only sees the latched miss address.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_stall  = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        start_miss = 1'b0;
        case (state)
            IDLE: begin
                if (in_req) begin
                    if (lookup_hit) begin
                        out_valid = 1'b1;
                    end else begin
                        out_stall  = 1'b1;
                        start_miss = 1'b1;
                        state_next = MISS;
                    end
                end
            end
            MISS: begin
                out_stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = miss_addr;
                if (mem_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                out_stall  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the line-aligned address of the missing PC so a redirect cannot disturb the fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_addr <= '0;
        end else if (start_miss) begin
            miss_addr <= {in_PC[31:4], 4'b0000};
        end
    end

    // Valid bits: invalidate clears all, but a same-edge fill still leaves its own line valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (in_invalidate) begin
                valid <= '0;
            end
            if (fill_we) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are written only by a completed fill and need no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= mem_rdata;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    assign out_hit_count  = hit_count;
    assign out_miss_count = miss_count;

    // Saturating event counters; invalidate deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (lookup_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache (NUM_LINES=4).
// Build with ICACHE_PERF_CNT_EN defined to also exercise the counters.
module tb_icache;

    logic         clk;
    logic         reset;
    logic [31:0]  in_PC;
    logic         in_req;
    logic         in_invalidate;
    logic [31:0]  out_instruction;
    logic         out_valid;
    logic         out_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ready;
    logic [127:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  out_hit_count;
    logic [31:0]  out_miss_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] LINE_B = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    localparam logic [127:0] LINE_C = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] LINE_D = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

    icache #(.NUM_LINES(4), .LINE_BITS(128)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_PC           (in_PC),
        .in_req          (in_req),
        .in_invalidate   (in_invalidate),
        .out_instruction (out_instruction),
        .out_valid       (out_valid),
        .out_stall       (out_stall),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .out_hit_count   (out_hit_count),
        .out_miss_count  (out_miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: called while the miss cycle is presented. Answers L cycles
    // after mem_req rises, optionally redirects in_PC / pulses invalidate at a
    // given MISS-relative cycle, and returns once back in IDLE.
    task automatic do_fill(input int lat, input logic [127:0] line,
                           input int redirect_c, input logic [31:0] redirect_pc,
                           input int inval_c,
                           output int req_n, output int stall_n,
                           output logic [31:0] addr, output logic done);
        req_n   = 0;
        stall_n = 0;
        addr    = 32'hFFFF_FFFF;
        done    = 1'b0;
        tick();
        for (int c = 0; c < 64; c++) begin
            if (c == redirect_c) in_PC = redirect_pc;
            in_invalidate = (c == inval_c);
            mem_ready     = (c == lat);
            mem_rdata     = (c == lat) ? line : 128'h0;
            @(negedge clk);
            if (out_stall) stall_n++;
            if (mem_req) begin
                req_n++;
                addr = mem_addr;
            end else if (req_n > 0) begin
                done = 1'b1;
            end
            tick();
            mem_ready     = 1'b0;
            in_invalidate = 1'b0;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid=%b stall=%b req=%b addr=%h, required 0 0 0 00000000",
                     out_valid, out_stall, mem_req, mem_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        int rq, st; logic [31:0] a; logic d;
        in_req = 1'b1;
        in_PC  = 32'h0;
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b1 || out_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cold_detect: stall=%b valid=%b req=%b, required 1 0 0", out_stall, out_valid, mem_req);
        end
        do_fill(3, LINE_A, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || rq != 4 || st != 5 || a !== 32'h0) begin
            errors++;
            $display("[TB] FAIL cold_timing: done=%b req_cycles=%0d stall_cycles=%0d addr=%h, required 1 4 5 00000000",
                     d, rq, st, a);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'h11 || out_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cold_replay: valid=%b instr=%h stall=%b, required 1 00000011 0",
                     out_valid, out_instruction, out_stall);
        end
    endtask

    task automatic test_sequential_hits();
        logic [31:0] exp_word [3];
        exp_word[0] = 32'h22;
        exp_word[1] = 32'h33;
        exp_word[2] = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick();
            in_PC = 32'(4 * (i + 1));
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_instruction !== exp_word[i] || mem_req !== 1'b0 || out_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL seq_hit pc=%h: valid=%b instr=%h req=%b stall=%b, required 1 %h 0 0",
                         in_PC, out_valid, out_instruction, mem_req, out_stall, exp_word[i]);
            end
        end
    endtask

    task automatic test_conflict();
        int rq, st; logic [31:0] a; logic d;
        tick();
        in_PC = 32'h40;
        @(negedge clk);
        do_fill(0, LINE_B, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || rq != 1 || st != 2 || a !== 32'h40) begin
            errors++;
            $display("[TB] FAIL conflict_fill40: done=%b req_cycles=%0d stall_cycles=%0d addr=%h, required 1 1 2 00000040",
                     d, rq, st, a);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'hB0) begin
            errors++;
            $display("[TB] FAIL conflict_hit40: valid=%b instr=%h, required 1 000000b0", out_valid, out_instruction);
        end
        tick();
        in_PC = 32'h0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_evicted: valid=%b stall=%b, required 0 1", out_valid, out_stall);
        end
        do_fill(1, LINE_A, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || a !== 32'h0 || st != 3) begin
            errors++;
            $display("[TB] FAIL conflict_refill0: done=%b addr=%h stall_cycles=%0d, required 1 00000000 3", d, a, st);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'h11) begin
            errors++;
            $display("[TB] FAIL conflict_hit0: valid=%b instr=%h, required 1 00000011", out_valid, out_instruction);
        end
    endtask

    task automatic test_redirect();
        int rq, st; logic [31:0] a; logic d;
        tick();
        in_PC = 32'h100;
        @(negedge clk);
        do_fill(2, LINE_C, 1, 32'h10, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || a !== 32'h100 || rq != 3) begin
            errors++;
            $display("[TB] FAIL redirect_fill: done=%b addr=%h req_cycles=%0d, required 1 00000100 3", d, a, rq);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redirect_new_miss: valid=%b stall=%b, required 0 1", out_valid, out_stall);
        end
        do_fill(0, LINE_D, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || a !== 32'h10) begin
            errors++;
            $display("[TB] FAIL redirect_fill10: done=%b addr=%h, required 1 00000010", d, a);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'hD0) begin
            errors++;
            $display("[TB] FAIL redirect_hit10: valid=%b instr=%h, required 1 000000d0", out_valid, out_instruction);
        end
        tick();
        in_PC = 32'h104;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'hC1) begin
            errors++;
            $display("[TB] FAIL redirect_installed100: valid=%b instr=%h, required 1 000000c1", out_valid, out_instruction);
        end
    endtask

    task automatic test_invalidate();
        int rq, st; logic [31:0] a; logic d;
        tick();
        in_PC         = 32'h100;
        in_invalidate = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_instruction !== 32'hC0) begin
            errors++;
            $display("[TB] FAIL inval_same_cycle: valid=%b instr=%h, required 1 000000c0", out_valid, out_instruction);
        end
        tick();
        in_invalidate = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inval_then_miss: valid=%b stall=%b, required 0 1", out_valid, out_stall);
        end
        do_fill(0, LINE_C, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || a !== 32'h100) begin
            errors++;
            $display("[TB] FAIL inval_refill: done=%b addr=%h, required 1 00000100", d, a);
        end
        // Invalidate exactly on the mem_ready edge of a fill of 0x10.
        tick();
        in_PC = 32'h10;
        @(negedge clk);
        checks++;
        if (out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inval_cleared10: stall=%b, required 1", out_stall);
        end
        do_fill(1, LINE_D, -1, 32'h0, 1, rq, st, a, d);
        @(negedge clk);
        checks++;
        if (d !== 1'b1 || out_valid !== 1'b1 || out_instruction !== 32'hD0) begin
            errors++;
            $display("[TB] FAIL inval_on_ready_kept: done=%b valid=%b instr=%h, required 1 1 000000d0",
                     d, out_valid, out_instruction);
        end
        tick();
        in_PC = 32'h100;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inval_on_ready_others: valid=%b stall=%b, required 0 1", out_valid, out_stall);
        end
        do_fill(0, LINE_C, -1, 32'h0, -1, rq, st, a, d);
    endtask

    task automatic test_reset_mid_miss();
        int rq, st; logic [31:0] a; logic d;
        tick();
        in_PC = 32'h20;
        tick();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin
            errors++;
            $display("[TB] FAIL rst_miss_req: req=%b addr=%h, required 1 00000020", mem_req, mem_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_PC = 32'h100;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || out_stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_miss_after: req=%b valid=%b stall=%b, required 0 0 1", mem_req, out_valid, out_stall);
        end
        do_fill(0, LINE_C, -1, 32'h0, -1, rq, st, a, d);
        checks++;
        if (d !== 1'b1 || a !== 32'h100) begin
            errors++;
            $display("[TB] FAIL rst_miss_refill: done=%b addr=%h, required 1 00000100", d, a);
        end
    endtask

`ifdef ICACHE_PERF_CNT_EN
    task automatic test_perf_counters();
        int rq, st; logic [31:0] a; logic d;
        in_req = 1'b0;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        in_req = 1'b1;
        in_PC  = 32'h0;
        @(negedge clk);
        do_fill(3, LINE_A, -1, 32'h0, -1, rq, st, a, d);
        tick();
        in_PC = 32'h4;
        tick();
        in_PC = 32'h8;
        tick();
        in_req = 1'b0;
        @(negedge clk);
        checks++;
        if (out_hit_count !== 32'd3 || out_miss_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL perf_counts: hits=%0d misses=%0d, required 3 1", out_hit_count, out_miss_count);
        end
        force dut.hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.hit_count;
        in_req = 1'b1;
        in_PC  = 32'h0;
        tick();
        in_req = 1'b0;
        @(negedge clk);
        checks++;
        if (out_hit_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL perf_saturate: hits=%h, required ffffffff", out_hit_count);
        end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        in_PC         = 32'h0;
        in_req        = 1'b0;
        in_invalidate = 1'b0;
        mem_ready     = 1'b0;
        mem_rdata     = 128'h0;
        test_reset();
        test_cold_miss();
        test_sequential_hits();
        test_conflict();
        test_redirect();
        test_invalidate();
        test_reset_mid_miss();
`ifdef ICACHE_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
